// File: rtl/ddr_sdram_local_arbiter.sv
// Two-port round-robin arbiter in front of the DDR SDRAM controller local interface.
// Splits word addresses into row/bank/col and steers in-order read data back via a tag FIFO.
module ddr_sdram_local_arbiter #(
    parameter int DATA_W    = 32,
    parameter int AWIDTH    = 23,
    parameter int TAG_DEPTH = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                a_read,
    input  logic                a_write,
    input  logic [AWIDTH-1:0]   a_addr,
    input  logic [1:0]          a_size,
    input  logic                a_burstbegin,
    input  logic [DATA_W-1:0]   a_wdata,
    input  logic [DATA_W/8-1:0] a_be,
    output logic                a_waitrequest,
    output logic [DATA_W-1:0]   a_rdata,
    output logic                a_rdata_valid,
    input  logic                b_read,
    input  logic                b_write,
    input  logic [AWIDTH-1:0]   b_addr,
    input  logic [1:0]          b_size,
    input  logic                b_burstbegin,
    input  logic [DATA_W-1:0]   b_wdata,
    input  logic [DATA_W/8-1:0] b_be,
    output logic                b_waitrequest,
    output logic [DATA_W-1:0]   b_rdata,
    output logic                b_rdata_valid,
    input  logic                local_ready,
    input  logic                local_init_done,
    input  logic [DATA_W-1:0]   local_rdata,
    input  logic                local_rdata_valid,
    output logic                local_read_req,
    output logic                local_write_req,
    output logic                local_burstbegin,
    output logic [1:0]          local_size,
    output logic [12:0]         local_row_addr,
    output logic [1:0]          local_bank_addr,
    output logic [7:0]          local_col_addr,
    output logic                local_cs_addr,
    output logic [DATA_W-1:0]   local_wdata,
    output logic [DATA_W/8-1:0] local_be,
    output logic                rd_err
);
    localparam int PW = $clog2(TAG_DEPTH);

    typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

    state_t              state_q, state_d;
    logic                last_grant_q, last_grant_d;   // 1 = B was granted last
    logic                beat_q, beat_d;
    logic                ret_beat_q, ret_beat_d;
    logic                rd_err_q, rd_err_d;
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]         count_q, count_d;
    logic [1:0]          tag_mem_q [TAG_DEPTH];        // {owner_is_b, two_beats}

    logic                own_a, own_b, own, req_a, req_b;
    logic                sel_rd, sel_wr, sel_two, sel_bb;
    logic [AWIDTH-1:0]   sel_addr;
    logic [1:0]          sel_size;
    logic [DATA_W-1:0]   sel_wdata;
    logic [DATA_W/8-1:0] sel_be;
    logic                fifo_empty, fifo_full, ret_beat, pop, push;
    logic                cmd_rd, issue_rd, issue_wr, blocked, accept;
    logic [1:0]          head;

    // Reset gates the grant so outputs take their idle values while reset is held.
    assign own_a = (state_q == OWN_A) && !reset;
    assign own_b = (state_q == OWN_B) && !reset;
    assign own   = own_a || own_b;
    assign req_a = a_read || a_write;
    assign req_b = b_read || b_write;

    always_comb begin : cmd_mux
        sel_rd    = a_read;
        sel_wr    = a_write;
        sel_addr  = a_addr;
        sel_size  = a_size;
        sel_bb    = a_burstbegin;
        sel_wdata = a_wdata;
        sel_be    = a_be;
        if (own_b) begin
            sel_rd    = b_read;
            sel_wr    = b_write;
            sel_addr  = b_addr;
            sel_size  = b_size;
            sel_bb    = b_burstbegin;
            sel_wdata = b_wdata;
            sel_be    = b_be;
        end
        sel_two = (sel_size == 2'd2) || (sel_size == 2'd3);
    end

    assign head       = tag_mem_q[rd_ptr_q];
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == (PW+1)'(TAG_DEPTH));
    assign ret_beat   = local_rdata_valid && !fifo_empty && !reset;
    assign pop        = ret_beat && (ret_beat_q == head[0]);

    // Reads are not allowed to interrupt a write burst already in progress.
    assign issue_wr = own && sel_wr;
    assign cmd_rd   = own && sel_rd && !sel_wr && !beat_q;
    assign blocked  = cmd_rd && fifo_full && !pop;
    assign issue_rd = cmd_rd && !blocked;
    assign accept   = local_ready && (issue_rd || issue_wr);
    assign push     = accept && issue_rd;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            beat_q       <= 1'b0;
            ret_beat_q   <= 1'b0;
            rd_err_q     <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            beat_q       <= beat_d;
            ret_beat_q   <= ret_beat_d;
            rd_err_q     <= rd_err_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem_q[wr_ptr_q] <= {own_b, sel_two};
        end
    end

    always_comb begin : fsm_next
        state_d      = state_q;
        last_grant_d = last_grant_q;
        beat_d       = beat_q;
        case (state_q)
            IDLE: begin
                if (local_init_done) begin
                    if (req_a && (!req_b || last_grant_q)) begin
                        state_d      = OWN_A;
                        last_grant_d = 1'b0;
                    end else if (req_b) begin
                        state_d      = OWN_B;
                        last_grant_d = 1'b1;
                    end
                end
            end
            OWN_A, OWN_B: begin
                if (accept) begin
                    if (issue_rd) begin
                        state_d = IDLE;
                    end else if (beat_q == sel_two) begin
                        state_d = IDLE;
                        beat_d  = 1'b0;
                    end else begin
                        beat_d = 1'b1;
                    end
                end else if (!beat_q && !sel_rd && !sel_wr) begin
                    // Requester withdrew before any beat; release rather than wait forever.
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin : tag_fifo_next
        wr_ptr_d   = wr_ptr_q + PW'(push);
        rd_ptr_d   = rd_ptr_q + PW'(pop);
        count_d    = count_q + (PW+1)'(push) - (PW+1)'(pop);
        ret_beat_d = ret_beat_q;
        if (pop) begin
            ret_beat_d = 1'b0;
        end else if (ret_beat) begin
            ret_beat_d = 1'b1;
        end
        rd_err_d = rd_err_q || (local_rdata_valid && fifo_empty);
    end

    always_comb begin : outputs
        a_waitrequest    = !(own_a && accept);
        b_waitrequest    = !(own_b && accept);
        local_read_req   = issue_rd;
        local_write_req  = issue_wr;
        local_burstbegin = (issue_rd || issue_wr) && sel_bb;
        local_size       = 2'd0;
        local_row_addr   = '0;
        local_bank_addr  = '0;
        local_col_addr   = '0;
        local_wdata      = '0;
        local_be         = '0;
        if (own) begin
            local_size      = sel_two ? 2'd2 : 2'd1;
            local_row_addr  = sel_addr[22:10];
            local_bank_addr = sel_addr[9:8];
            local_col_addr  = sel_addr[7:0];
            local_wdata     = sel_wdata;
            local_be        = sel_be;
        end
        local_cs_addr = 1'b0;
        a_rdata       = local_rdata;
        b_rdata       = local_rdata;
        a_rdata_valid = ret_beat && !head[1];
        b_rdata_valid = ret_beat && head[1];
        rd_err        = rd_err_q;
    end
endmodule

// File: tb/tb_ddr_sdram_local_arbiter.sv
// Bench for ddr_sdram_local_arbiter: directed phases plus command and read-return scoreboards.
module tb_ddr_sdram_local_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        a_read, a_write, a_burstbegin, a_waitrequest, a_rdata_valid;
    logic [22:0] a_addr;
    logic [1:0]  a_size;
    logic [31:0] a_wdata, a_rdata;
    logic [3:0]  a_be;
    logic        b_read, b_write, b_burstbegin, b_waitrequest, b_rdata_valid;
    logic [22:0] b_addr;
    logic [1:0]  b_size;
    logic [31:0] b_wdata, b_rdata;
    logic [3:0]  b_be;
    logic        local_ready, local_init_done, local_rdata_valid;
    logic [31:0] local_rdata, local_wdata;
    logic        local_read_req, local_write_req, local_burstbegin, local_cs_addr;
    logic [1:0]  local_size, local_bank_addr;
    logic [12:0] local_row_addr;
    logic [7:0]  local_col_addr;
    logic [3:0]  local_be;
    logic        rd_err;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [71:0] exp_q[$];
    logic [1:0]  ret_q[$];
    logic [1:0]  exp_rv;

    localparam logic [71:0] RST_VEC = {2'b00, 4'b1100, 66'd0};

    always #5 clk = ~clk;

    ddr_sdram_local_arbiter dut (
        .clk(clk), .reset(reset),
        .a_read(a_read), .a_write(a_write), .a_addr(a_addr), .a_size(a_size),
        .a_burstbegin(a_burstbegin), .a_wdata(a_wdata), .a_be(a_be),
        .a_waitrequest(a_waitrequest), .a_rdata(a_rdata), .a_rdata_valid(a_rdata_valid),
        .b_read(b_read), .b_write(b_write), .b_addr(b_addr), .b_size(b_size),
        .b_burstbegin(b_burstbegin), .b_wdata(b_wdata), .b_be(b_be),
        .b_waitrequest(b_waitrequest), .b_rdata(b_rdata), .b_rdata_valid(b_rdata_valid),
        .local_ready(local_ready), .local_init_done(local_init_done),
        .local_rdata(local_rdata), .local_rdata_valid(local_rdata_valid),
        .local_read_req(local_read_req), .local_write_req(local_write_req),
        .local_burstbegin(local_burstbegin), .local_size(local_size),
        .local_row_addr(local_row_addr), .local_bank_addr(local_bank_addr),
        .local_col_addr(local_col_addr), .local_cs_addr(local_cs_addr),
        .local_wdata(local_wdata), .local_be(local_be), .rd_err(rd_err)
    );

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected controller-side view of one accepted beat.
    function automatic logic [71:0] mk_cmd(input bit bb, input bit who_b, input bit wr,
                                           input logic [22:0] addr, input logic [1:0] size,
                                           input logic [31:0] wdata, input logic [3:0] be);
        return {6'b0, bb, !who_b, who_b, wr, !wr, addr[22:10], addr[9:8], addr[7:0],
                (size[1] ? 2'd2 : 2'd1), wdata, be};
    endfunction

    function automatic logic [71:0] out_vec();
        return {2'b0, a_waitrequest, b_waitrequest, a_rdata_valid, b_rdata_valid,
                local_read_req, local_write_req, local_burstbegin, local_size, local_cs_addr,
                rd_err, local_row_addr, local_bank_addr, local_col_addr, local_wdata, local_be};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit who_b, input bit rd, input bit wr, input logic [22:0] addr,
                         input logic [1:0] size, input logic [31:0] wdata, input logic [3:0] be,
                         input bit bb);
        if (who_b) begin
            b_read = rd; b_write = wr; b_addr = addr; b_size = size;
            b_wdata = wdata; b_be = be; b_burstbegin = bb;
        end else begin
            a_read = rd; a_write = wr; a_addr = addr; a_size = size;
            a_wdata = wdata; a_be = be; a_burstbegin = bb;
        end
    endtask

    task automatic wait_accept(input bit who_b);
        int n = 0;
        forever begin
            @(negedge clk);
            if ((who_b ? b_waitrequest : a_waitrequest) == 1'b0) break;
            n++;
            if (n > 200) begin
                check("accept_timeout", 72'(n), 72'd0);
                break;
            end
        end
        tick();
    endtask

    task automatic issue(input bit who_b, input bit wr, input logic [22:0] addr,
                         input logic [1:0] size, input logic [31:0] wdata, input logic [3:0] be);
        int beats = (wr && size[1]) ? 2 : 1;
        for (int i = 0; i < beats; i++) begin
            drive(who_b, !wr, wr, addr, size, wr ? wdata + 32'(i) : 32'h0, wr ? be : 4'h0, i == 0);
            wait_accept(who_b);
        end
        drive(who_b, 0, 0, 23'h0, 2'd0, 32'h0, 4'h0, 0);
    endtask

    task automatic ret(input logic [31:0] d);
        local_rdata       = d;
        local_rdata_valid = 1'b1;
        tick();
        local_rdata_valid = 1'b0;
    endtask

    // Scoreboards: accepted beats and returned read data.
    always @(negedge clk) begin
        if (!reset) begin
            if (local_ready && (local_read_req || local_write_req)) begin
                if (exp_q.size() == 0)
                    check("cmd_unexpected", {6'b0, local_burstbegin, !a_waitrequest, !b_waitrequest,
                          local_write_req, local_read_req, local_row_addr, local_bank_addr,
                          local_col_addr, local_size, local_wdata, local_be}, 72'd0);
                else
                    check("cmd", {6'b0, local_burstbegin, !a_waitrequest, !b_waitrequest,
                          local_write_req, local_read_req, local_row_addr, local_bank_addr,
                          local_col_addr, local_size, local_wdata, local_be}, exp_q.pop_front());
            end
            if (local_rdata_valid) begin
                exp_rv = (ret_q.size() != 0) ? ret_q.pop_front() : 2'b00;
                check("rvalid", {a_rdata_valid, b_rdata_valid}, exp_rv);
                check("rdata", {a_rdata, b_rdata}, {local_rdata, local_rdata});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        local_ready = 1'b1; local_init_done = 1'b1;
        local_rdata = 32'h0; local_rdata_valid = 1'b0;
        drive(1, 0, 0, 23'h0, 2'd0, 32'h0, 4'h0, 0);
        drive(0, 0, 1, 23'h12345, 2'd1, 32'h1111_2222, 4'hF, 1);
        tick(); tick();
        @(negedge clk);
        check("rst_during", out_vec(), RST_VEC);
        tick();
        drive(0, 0, 0, 23'h0, 2'd0, 32'h0, 4'h0, 0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_after", out_vec(), RST_VEC);
        tick();

        // Contention: A wins first, then strict alternation.
        exp_q.push_back(mk_cmd(1, 0, 0, 23'h100, 2'd1, 32'h0, 4'h0));
        exp_q.push_back(mk_cmd(1, 1, 0, 23'h200, 2'd1, 32'h0, 4'h0));
        exp_q.push_back(mk_cmd(1, 0, 0, 23'h101, 2'd1, 32'h0, 4'h0));
        exp_q.push_back(mk_cmd(1, 1, 0, 23'h201, 2'd1, 32'h0, 4'h0));
        ret_q.push_back(2'b10); ret_q.push_back(2'b01);
        ret_q.push_back(2'b10); ret_q.push_back(2'b01);
        fork
            begin
                issue(0, 0, 23'h100, 2'd1, 32'h0, 4'h0);
                issue(0, 0, 23'h101, 2'd1, 32'h0, 4'h0);
            end
            begin
                issue(1, 0, 23'h200, 2'd1, 32'h0, 4'h0);
                issue(1, 0, 23'h201, 2'd1, 32'h0, 4'h0);
            end
        join
        for (int i = 0; i < 4; i++) ret(32'h1000 + 32'(i));
        check("contention_drained", 72'(exp_q.size() + ret_q.size()), 72'd0);

        // Single write from A: one-cycle arbitration latency, single accept cycle.
        exp_q.push_back(mk_cmd(1, 0, 1, 23'h12345, 2'd1, 32'hDEADBEEF, 4'hF));
        drive(0, 0, 1, 23'h12345, 2'd1, 32'hDEADBEEF, 4'hF, 1);
        @(negedge clk);
        check("sw_c0", {a_waitrequest, local_write_req}, 2'b10);
        tick();
        @(negedge clk);
        check("sw_c1", {a_waitrequest, local_write_req, local_row_addr, local_bank_addr, local_col_addr},
              {1'b0, 1'b1, 13'h048, 2'd3, 8'h45});
        tick();
        drive(0, 0, 0, 23'h0, 2'd0, 32'h0, 4'h0, 0);
        @(negedge clk);
        check("sw_c2", {a_waitrequest, local_write_req}, 2'b10);
        tick();

        // Two-beat write from B under backpressure while A is also requesting.
        exp_q.push_back(mk_cmd(1, 1, 1, 23'h7FFFFF, 2'd2, 32'hA5A5_0000, 4'h3));
        exp_q.push_back(mk_cmd(0, 1, 1, 23'h7FFFFF, 2'd2, 32'hA5A5_0001, 4'h3));
        exp_q.push_back(mk_cmd(1, 0, 1, 23'h000001, 2'd1, 32'h1234_5678, 4'hF));
        drive(1, 0, 1, 23'h7FFFFF, 2'd2, 32'hA5A5_0000, 4'h3, 1);
        @(negedge clk);
        check("bst_c0", {b_waitrequest, local_write_req}, 2'b10);
        tick();
        drive(0, 0, 1, 23'h000001, 2'd1, 32'h1234_5678, 4'hF, 1);
        @(negedge clk);
        check("bst_c1", {a_waitrequest, b_waitrequest, local_burstbegin, local_size}, {3'b101, 2'd2});
        tick();
        drive(1, 0, 1, 23'h7FFFFF, 2'd2, 32'hA5A5_0001, 4'h3, 0);
        local_ready = 1'b0;
        @(negedge clk);
        check("bst_c2", {a_waitrequest, b_waitrequest, local_write_req, local_burstbegin}, 4'b1110);
        tick();
        local_ready = 1'b1;
        @(negedge clk);
        check("bst_c3", {a_waitrequest, b_waitrequest, local_write_req, local_burstbegin}, 4'b1010);
        tick();
        drive(1, 0, 0, 23'h0, 2'd0, 32'h0, 4'h0, 0);
        wait_accept(0);
        drive(0, 0, 0, 23'h0, 2'd0, 32'h0, 4'h0, 0);

        // Fill the tag FIFO, write from B while full, then a held 9th read.
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(mk_cmd(1, 0, 0, 23'h400 + 23'(i), 2'd1, 32'h0, 4'h0));
            ret_q.push_back(2'b10);
            issue(0, 0, 23'h400 + 23'(i), 2'd1, 32'h0, 4'h0);
        end
        exp_q.push_back(mk_cmd(1, 1, 1, 23'h500, 2'd1, 32'hCAFE_0001, 4'hF));
        issue(1, 1, 23'h500, 2'd1, 32'hCAFE_0001, 4'hF);
        exp_q.push_back(mk_cmd(1, 0, 0, 23'h408, 2'd1, 32'h0, 4'h0));
        ret_q.push_back(2'b10);
        drive(0, 1, 0, 23'h408, 2'd1, 32'h0, 4'h0, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("full_hold", {a_waitrequest, local_read_req}, 2'b10);
            tick();
        end
        local_rdata = 32'h900; local_rdata_valid = 1'b1;
        @(negedge clk);
        check("full_release", {a_waitrequest, local_read_req}, 2'b01);
        tick();
        local_rdata_valid = 1'b0;
        drive(0, 0, 0, 23'h0, 2'd0, 32'h0, 4'h0, 0);
        for (int i = 0; i < 8; i++) ret(32'h901 + 32'(i));
        check("full_drained", 72'(exp_q.size() + ret_q.size()), 72'd0);

        // Return with empty FIFO, then a size-3 read returning two beats.
        ret(32'hBAD0_0001);
        @(negedge clk);
        check("rd_err_set", {rd_err, a_rdata_valid, b_rdata_valid}, 3'b100);
        tick();
        exp_q.push_back(mk_cmd(1, 0, 0, 23'h600, 2'd3, 32'h0, 4'h0));
        ret_q.push_back(2'b10); ret_q.push_back(2'b10);
        issue(0, 0, 23'h600, 2'd3, 32'h0, 4'h0);
        ret(32'h6001); ret(32'h6002); ret(32'h6003);
        check("two_beat_ret_drained", 72'(ret_q.size()), 72'd0);

        // Reset mid write burst with a read outstanding.
        exp_q.push_back(mk_cmd(1, 1, 0, 23'h700, 2'd1, 32'h0, 4'h0));
        issue(1, 0, 23'h700, 2'd1, 32'h0, 4'h0);
        exp_q.push_back(mk_cmd(1, 0, 1, 23'h2AAAA, 2'd2, 32'h7700, 4'hF));
        drive(0, 0, 1, 23'h2AAAA, 2'd2, 32'h7700, 4'hF, 1);
        wait_accept(0);
        drive(0, 0, 1, 23'h2AAAA, 2'd2, 32'h7701, 4'hF, 0);
        reset = 1'b1;
        exp_q.delete();
        ret_q.delete();
        tick();
        reset = 1'b0;
        drive(0, 0, 0, 23'h0, 2'd0, 32'h0, 4'h0, 0);
        @(negedge clk);
        check("rst_mid_burst", out_vec(), RST_VEC);
        tick();
        ret(32'h777);
        @(negedge clk);
        check("rd_err_after_rst", {rd_err, a_rdata_valid, b_rdata_valid}, 3'b100);
        tick();
        check("final_queues", 72'(exp_q.size() + ret_q.size()), 72'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
